// File: rtl/kbd_fifo_pkg.sv
// Shared definitions for the keyboard scancode buffer: prefix bytes, entry
// layout and prefix-FSM state encoding.
package kbd_fifo_pkg;

   localparam logic [7:0] PS2_E0 = 8'hE0;
   localparam logic [7:0] PS2_F0 = 8'hF0;

   localparam int ENTRY_W  = 10;
   localparam int CODE_MSB = 7;
   localparam int CODE_LSB = 0;
   localparam int BRK_BIT  = 8;
   localparam int EXT_BIT  = 9;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BRK     = 2'd1,
      ST_EXT     = 2'd2,
      ST_EXT_BRK = 2'd3
   } pfx_state_e;

   function automatic logic [ENTRY_W-1:0] make_entry(input logic ext,
                                                     input logic brk,
                                                     input logic [7:0] code);
      return {ext, brk, code};
   endfunction

endpackage

// File: rtl/kbd_fifo_sync.sv
// Register-array FIFO with a show-ahead head; the head reads as zero while empty.
// Pointers wrap naturally, occupancy is tracked in a separate counter.
module fifo_sync #(
   parameter int WIDTH      = 10,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clock_i,
   input  logic                  reset_i,
   input  logic                  flush_i,
   input  logic                  push_i,
   input  logic [WIDTH-1:0]      wdata_i,
   input  logic                  pop_i,
   output logic [WIDTH-1:0]      rdata_o,
   output logic [DEPTH_LOG2:0]   count_o,
   output logic                  full_o,
   output logic                  empty_o
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CW    = DEPTH_LOG2 + 1;
   localparam logic [DEPTH_LOG2:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0]      mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  do_push_s, do_pop_s;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == FULL_CNT);
   assign count_o = count_q;
   assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

   // A pop frees a slot in the same cycle, so push while full is fine when popping.
   assign do_pop_s  = pop_i & ~empty_o & ~flush_i;
   assign do_push_s = push_i & (~full_o | do_pop_s) & ~flush_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push_s) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         count_d = count_d;
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clock_i) begin
      if (do_push_s) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/kbd_fifo.sv
// PS/2 set-2 scancode buffer: folds E0/F0 prefixes into ext/brk flags and
// queues {ext,brk,code} entries for portctl; irq tracks FIFO non-empty.
module kbd_fifo
   import kbd_fifo_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4,
   parameter int TIMEOUT    = 500000
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [7:0]            ps2_data,
   input  logic                  ps2_hit,
   input  logic                  rd,
   input  logic                  clr,
   output logic [7:0]            q_code,
   output logic                  q_brk,
   output logic                  q_ext,
   output logic                  q_valid,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  overflow,
   output logic                  irq
);
   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

   pfx_state_e           state_q, state_d;
   logic [TW-1:0]        tmo_q, tmo_d;
   logic                 push_q, push_d;
   logic [ENTRY_W-1:0]   entry_q, entry_d;
   logic                 overflow_q, overflow_d;
   logic [ENTRY_W-1:0]   head_s;
   logic                 full_s, empty_s;
   logic                 is_e0_s, is_f0_s;

   assign is_e0_s = (ps2_data == PS2_E0);
   assign is_f0_s = (ps2_data == PS2_F0);

   always_comb begin
      state_d = state_q;
      tmo_d   = tmo_q;
      push_d  = 1'b0;
      entry_d = entry_q;
      if (ps2_hit) begin
         tmo_d = '0;
         case (state_q)
            ST_IDLE: begin
               if (is_e0_s) begin
                  state_d = ST_EXT;
               end else if (is_f0_s) begin
                  state_d = ST_BRK;
               end else begin
                  push_d  = 1'b1;
                  entry_d = make_entry(1'b0, 1'b0, ps2_data);
               end
            end
            ST_BRK: begin
               if (is_f0_s) begin
                  state_d = ST_BRK;
               end else if (is_e0_s) begin
                  state_d = ST_EXT_BRK;
               end else begin
                  push_d  = 1'b1;
                  entry_d = make_entry(1'b0, 1'b1, ps2_data);
                  state_d = ST_IDLE;
               end
            end
            ST_EXT: begin
               if (is_f0_s) begin
                  state_d = ST_EXT_BRK;
               end else if (is_e0_s) begin
                  state_d = ST_EXT;
               end else begin
                  push_d  = 1'b1;
                  entry_d = make_entry(1'b1, 1'b0, ps2_data);
                  state_d = ST_IDLE;
               end
            end
            ST_EXT_BRK: begin
               if (is_e0_s || is_f0_s) begin
                  state_d = ST_EXT_BRK;
               end else begin
                  push_d  = 1'b1;
                  entry_d = make_entry(1'b1, 1'b1, ps2_data);
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end else if (state_q != ST_IDLE) begin
         // A stalled prefix is abandoned so a lost byte cannot taint later codes.
         if (tmo_q == TO_LAST) begin
            state_d = ST_IDLE;
            tmo_d   = '0;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end else begin
         tmo_d = '0;
      end
      if (clr) begin
         state_d = ST_IDLE;
         tmo_d   = '0;
         push_d  = 1'b0;
      end else begin
         push_d = push_d;
      end
   end

   always_comb begin
      overflow_d = overflow_q;
      if (clr) begin
         overflow_d = 1'b0;
      end else if (push_q && full_s && !(rd && !empty_s)) begin
         overflow_d = 1'b1;
      end else begin
         overflow_d = overflow_q;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         tmo_q      <= '0;
         push_q     <= 1'b0;
         entry_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tmo_q      <= tmo_d;
         push_q     <= push_d;
         entry_q    <= entry_d;
         overflow_q <= overflow_d;
      end
   end

   fifo_sync #(
      .WIDTH      (ENTRY_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clock_i (clock),
      .reset_i (reset),
      .flush_i (clr),
      .push_i  (push_q),
      .wdata_i (entry_q),
      .pop_i   (rd),
      .rdata_o (head_s),
      .count_o (count),
      .full_o  (full_s),
      .empty_o (empty_s)
   );

   assign q_code   = head_s[CODE_MSB:CODE_LSB];
   assign q_brk    = head_s[BRK_BIT];
   assign q_ext    = head_s[EXT_BIT];
   assign q_valid  = ~empty_s;
   assign irq      = ~empty_s;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_kbd_fifo.sv
// Directed bench for kbd_fifo: prefix folding, latency, overflow, full
// push/pop, prefix timeout, clr priority and empty reads.
module tb_kbd_fifo;
   localparam int TO = 16;

   logic       clock = 1'b0;
   logic       reset, ps2_hit, rd, clr;
   logic [7:0] ps2_data;
   logic [7:0] q_code;
   logic       q_brk, q_ext, q_valid, overflow, irq;
   logic [4:0] count;
   int         total = 0;
   int         bad   = 0;

   kbd_fifo #(.DEPTH_LOG2(4), .TIMEOUT(TO)) dut (
      .clock(clock), .reset(reset), .ps2_data(ps2_data), .ps2_hit(ps2_hit),
      .rd(rd), .clr(clr), .q_code(q_code), .q_brk(q_brk), .q_ext(q_ext),
      .q_valid(q_valid), .count(count), .overflow(overflow), .irq(irq)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      ps2_data = b;
      ps2_hit  = 1'b1;
      tick();
      ps2_hit  = 1'b0;
   endtask

   task automatic pop();
      rd = 1'b1;
      tick();
      rd = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; ps2_hit = 1'b0; rd = 1'b0; clr = 1'b0; ps2_data = 8'h00;
      tick(); tick();
      reset = 1'b0;
      total++;
      if ({count, q_valid, irq, overflow, q_code, q_brk, q_ext} !== {5'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL reset: cnt=%0d v=%b irq=%b ovf=%b code=%h required all zero", count, q_valid, irq, overflow, q_code);
      end
   endtask

   task automatic test_single();
      send(8'h1C);
      total++;
      if (q_valid !== 1'b0) begin
         bad++; $display("FAIL latency1: q_valid=%b required 0", q_valid);
      end
      tick();
      total++;
      if ({q_code, q_brk, q_ext, count, irq, q_valid} !== {8'h1C, 1'b0, 1'b0, 5'd1, 1'b1, 1'b1}) begin
         bad++; $display("FAIL single: code=%h brk=%b ext=%b cnt=%0d irq=%b required 1C 0 0 1 1", q_code, q_brk, q_ext, count, irq);
      end
      pop();
      total++;
      if ({q_valid, irq, count} !== {1'b0, 1'b0, 5'd0}) begin
         bad++; $display("FAIL single_pop: v=%b irq=%b cnt=%0d required 0 0 0", q_valid, irq, count);
      end
   endtask

   task automatic test_prefixes();
      send(8'hF0); send(8'h1C); tick();
      total++;
      if ({count, q_code, q_brk, q_ext} !== {5'd1, 8'h1C, 1'b1, 1'b0}) begin
         bad++; $display("FAIL brk: cnt=%0d code=%h brk=%b ext=%b required 1 1C 1 0", count, q_code, q_brk, q_ext);
      end
      pop();
      send(8'hE0); send(8'hF0); send(8'h75); tick();
      total++;
      if ({count, q_code, q_brk, q_ext} !== {5'd1, 8'h75, 1'b1, 1'b1}) begin
         bad++; $display("FAIL ext_brk: cnt=%0d code=%h brk=%b ext=%b required 1 75 1 1", count, q_code, q_brk, q_ext);
      end
      pop();
      send(8'hE0); send(8'hE0); send(8'h6B); tick();
      total++;
      if ({count, q_code, q_brk, q_ext} !== {5'd1, 8'h6B, 1'b0, 1'b1}) begin
         bad++; $display("FAIL ext: cnt=%0d code=%h brk=%b ext=%b required 1 6B 0 1", count, q_code, q_brk, q_ext);
      end
      pop();
      send(8'hF0); send(8'hE0); send(8'h11); tick();
      total++;
      if ({count, q_code, q_brk, q_ext} !== {5'd1, 8'h11, 1'b1, 1'b1}) begin
         bad++; $display("FAIL brk_e0: cnt=%0d code=%h brk=%b ext=%b required 1 11 1 1", count, q_code, q_brk, q_ext);
      end
      pop();
      send(8'hE1); send(8'hAA); tick();
      total++;
      if ({count, q_code, q_brk, q_ext} !== {5'd2, 8'hE1, 1'b0, 1'b0}) begin
         bad++; $display("FAIL raw_e1: cnt=%0d code=%h brk=%b ext=%b required 2 E1 0 0", count, q_code, q_brk, q_ext);
      end
      pop();
      total++;
      if ({count, q_code} !== {5'd1, 8'hAA}) begin
         bad++; $display("FAIL raw_aa: cnt=%0d code=%h required 1 AA", count, q_code);
      end
      pop();
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 17; i++) send(8'h10 + 8'(i));
      tick();
      total++;
      if ({count, overflow} !== {5'd16, 1'b1}) begin
         bad++; $display("FAIL ovf_fill: cnt=%0d ovf=%b required 16 1", count, overflow);
      end
      for (int i = 0; i < 16; i++) begin
         total++;
         if (q_code !== 8'h10 + 8'(i)) begin
            bad++; $display("FAIL ovf_order%0d: code=%h required %h", i, q_code, 8'h10 + 8'(i));
         end
         pop();
      end
      total++;
      if ({count, q_valid, overflow} !== {5'd0, 1'b0, 1'b1}) begin
         bad++; $display("FAIL ovf_drain: cnt=%0d v=%b ovf=%b required 0 0 1", count, q_valid, overflow);
      end
      clr = 1'b1; tick(); clr = 1'b0;
      total++;
      if ({count, overflow} !== {5'd0, 1'b0}) begin
         bad++; $display("FAIL ovf_clr: cnt=%0d ovf=%b required 0 0", count, overflow);
      end
   endtask

   task automatic test_full_push_pop();
      for (int i = 0; i < 16; i++) send(8'h30 + 8'(i));
      tick();
      send(8'h55);
      rd = 1'b1; tick(); rd = 1'b0;
      total++;
      if ({count, overflow, q_code} !== {5'd16, 1'b0, 8'h31}) begin
         bad++; $display("FAIL full_pp: cnt=%0d ovf=%b code=%h required 16 0 31", count, overflow, q_code);
      end
      for (int i = 1; i < 16; i++) pop();
      total++;
      if ({count, q_code} !== {5'd1, 8'h55}) begin
         bad++; $display("FAIL full_tail: cnt=%0d code=%h required 1 55", count, q_code);
      end
      pop();
   endtask

   task automatic test_timeout();
      send(8'hE0);
      repeat (TO) tick();
      send(8'h1C); tick();
      total++;
      if ({count, q_code, q_ext, q_brk} !== {5'd1, 8'h1C, 1'b0, 1'b0}) begin
         bad++; $display("FAIL timeout: cnt=%0d code=%h ext=%b brk=%b required 1 1C 0 0", count, q_code, q_ext, q_brk);
      end
      pop();
      send(8'hE0);
      repeat (TO - 1) tick();
      send(8'h1C); tick();
      total++;
      if ({count, q_code, q_ext} !== {5'd1, 8'h1C, 1'b1}) begin
         bad++; $display("FAIL timeout_edge: cnt=%0d code=%h ext=%b required 1 1C 1", count, q_code, q_ext);
      end
      pop();
      send(8'hE0); send(8'hF0);
      reset = 1'b1; tick(); reset = 1'b0;
      send(8'h1C); tick();
      total++;
      if ({count, q_code, q_ext, q_brk} !== {5'd1, 8'h1C, 1'b0, 1'b0}) begin
         bad++; $display("FAIL reset_fsm: cnt=%0d code=%h ext=%b brk=%b required 1 1C 0 0", count, q_code, q_ext, q_brk);
      end
      pop();
   endtask

   task automatic test_clr_and_empty();
      ps2_data = 8'h1C; ps2_hit = 1'b1; clr = 1'b1; tick();
      ps2_hit = 1'b0; clr = 1'b0;
      tick(); tick();
      total++;
      if ({count, q_valid} !== {5'd0, 1'b0}) begin
         bad++; $display("FAIL clr_hit: cnt=%0d v=%b required 0 0", count, q_valid);
      end
      send(8'h2A);
      clr = 1'b1; tick(); clr = 1'b0;
      tick();
      total++;
      if (count !== 5'd0) begin
         bad++; $display("FAIL clr_pending: cnt=%0d required 0", count);
      end
      pop();
      total++;
      if (count !== 5'd0) begin
         bad++; $display("FAIL rd_empty: cnt=%0d required 0", count);
      end
      send(8'h3B); tick();
      total++;
      if ({count, q_code} !== {5'd1, 8'h3B}) begin
         bad++; $display("FAIL after_empty_rd: cnt=%0d code=%h required 1 3B", count, q_code);
      end
      pop();
      send(8'h4C);
      rd = 1'b1; tick(); rd = 1'b0;
      total++;
      if ({count, q_code} !== {5'd1, 8'h4C}) begin
         bad++; $display("FAIL empty_push_rd: cnt=%0d code=%h required 1 4C", count, q_code);
      end
      pop();
   endtask

   initial begin
      test_reset();
      test_single();
      test_prefixes();
      test_overflow();
      test_full_push_pop();
      test_timeout();
      test_clr_and_empty();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
